// File: rtl/hc595_receiver.sv
// Serial-to-parallel receiver for the ds/shcp/stcp/oe display link (74HC595 far-end model).
// Optional frame-length checking is enabled by defining HC595_FRAME_CHECK_EN.
module hc595_receiver #(
  parameter int SEL_W = 6,
  parameter int SEG_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ds,
  input  logic             shcp,
  input  logic             stcp,
  input  logic             oe,
  output logic [SEL_W-1:0] sel,
  output logic [SEG_W-1:0] seg,
  output logic             frame_valid,
  output logic             frame_err
);

  localparam int W  = SEL_W + SEG_W;
  localparam int CW = $clog2(W + 2);
  localparam logic [CW-1:0] CNT_FULL = CW'(W);
  localparam logic [CW-1:0] CNT_MAX  = CW'(W + 1);

  // Synchronizer chains: bit 0 is s1, bit 1 is s2, bit 2 (edge-detect history) is s3.
  logic [1:0]   ds_s_q;
  logic [2:0]   shcp_s_q;
  logic [2:0]   stcp_s_q;
  logic [1:0]   oe_s_q;

  logic [W-1:0]  sr_q, sr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  storage_q, storage_d;
  logic          valid_q, valid_d;
  logic          err_d;

  logic shcp_rise;
  logic stcp_rise;

  assign shcp_rise = shcp_s_q[1] & ~shcp_s_q[2];
  assign stcp_rise = stcp_s_q[1] & ~stcp_s_q[2];

  always_comb begin
    sr_d      = sr_q;
    cnt_d     = cnt_q;
    storage_d = storage_q;
    valid_d   = 1'b0;
    err_d     = 1'b0;

    // The latch decision uses the pre-shift sr and cnt, so a coincident shift
    // bit belongs to the next frame.
    if (stcp_rise) begin
      if (cnt_q == CNT_FULL) begin
        storage_d = sr_q;
        valid_d   = 1'b1;
      end else if (cnt_q != '0) begin
`ifdef HC595_FRAME_CHECK_EN
        err_d = 1'b1;
`else
        storage_d = sr_q;
        valid_d   = 1'b1;
`endif
      end
      cnt_d = shcp_rise ? CW'(1) : '0;
    end else if (shcp_rise && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CW'(1);
    end

    if (shcp_rise) begin
      sr_d = {ds_s_q[1], sr_q[W-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ds_s_q    <= '0;
      shcp_s_q  <= '0;
      stcp_s_q  <= '0;
      oe_s_q    <= '0;
      sr_q      <= '0;
      cnt_q     <= '0;
      storage_q <= '0;
      valid_q   <= 1'b0;
    end else begin
      ds_s_q    <= {ds_s_q[0], ds};
      shcp_s_q  <= {shcp_s_q[1:0], shcp};
      stcp_s_q  <= {stcp_s_q[1:0], stcp};
      oe_s_q    <= {oe_s_q[0], oe};
      sr_q      <= sr_d;
      cnt_q     <= cnt_d;
      storage_q <= storage_d;
      valid_q   <= valid_d;
    end
  end

`ifdef HC595_FRAME_CHECK_EN
  logic err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign frame_err = err_q;
`else
  logic unused_err;
  assign unused_err = err_d;
  assign frame_err  = 1'b0;
`endif

  // oe is active-low; storage itself is never touched by blanking.
  assign sel         = oe_s_q[1] ? '0 : storage_q[SEL_W-1:0];
  assign seg         = oe_s_q[1] ? '0 : storage_q[W-1:SEL_W];
  assign frame_valid = valid_q;

endmodule

// File: tb/tb_hc595_receiver.sv
// Self-checking bench for hc595_receiver: directed steps plus random frames checked
// against a bit-history model of the link.
module tb_hc595_receiver;

  localparam int SEL_W = 6;
  localparam int SEG_W = 8;
  localparam int W     = SEL_W + SEG_W;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             ds = 1'b0;
  logic             shcp = 1'b0;
  logic             stcp = 1'b0;
  logic             oe = 1'b0;
  logic [SEL_W-1:0] sel;
  logic [SEG_W-1:0] seg;
  logic             frame_valid;
  logic             frame_err;

  hc595_receiver #(.SEL_W(SEL_W), .SEG_W(SEG_W)) dut (
    .clk(clk), .rst(rst), .ds(ds), .shcp(shcp), .stcp(stcp), .oe(oe),
    .sel(sel), .seg(seg), .frame_valid(frame_valid), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  // Reference model: every bit ever shifted since reset, bits since last latch,
  // the stored frame and the current oe level.
  bit        hist[$];
  int        nbits;
  bit [13:0] storage_m;
  bit        oe_m;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  function automatic bit [13:0] last_frame();
    bit [13:0] v = '0;
    for (int i = 0; i < W; i++) begin
      int idx = hist.size() - W + i;
      if (idx >= 0) v[i] = hist[idx];
    end
    return v;
  endfunction

  task automatic check_outputs(input string tag);
    check({tag, ".sel"}, 32'(sel), oe_m ? 32'd0 : 32'(storage_m[SEL_W-1:0]));
    check({tag, ".seg"}, 32'(seg), oe_m ? 32'd0 : 32'(storage_m[W-1:SEL_W]));
  endtask

  task automatic shift_bit(input bit b);
    ds = b;
    tick(); tick();
    shcp = 1'b1;
    hist.push_back(b);
    nbits++;
    tick(); tick();
    shcp = 1'b0;
  endtask

  task automatic shift_word(input int n, input logic [31:0] v);
    for (int i = 0; i < n; i++) shift_bit(v[i]);
  endtask

  // Raises stcp (optionally with a coincident shcp carrying bit b) and checks the
  // pulse lands exactly on the third sampled cycle.
  task automatic latch(input string tag, input bit simul, input bit b);
    int  cnt_m;
    bit  exp_v, exp_e;
    if (simul) ds = b;
    tick(); tick();
    cnt_m = (nbits > W + 1) ? W + 1 : nbits;
    exp_v = 1'b0;
    exp_e = 1'b0;
    if (cnt_m == W) begin
      exp_v = 1'b1;
    end else if (cnt_m != 0) begin
`ifdef HC595_FRAME_CHECK_EN
      exp_e = 1'b1;
`else
      exp_v = 1'b1;
`endif
    end
    if (exp_v) storage_m = last_frame();
    nbits = 0;
    stcp = 1'b1;
    if (simul) begin
      shcp = 1'b1;
      hist.push_back(b);
      nbits = 1;
    end
    tick(); tick();
    check({tag, ".early_valid"}, 32'(frame_valid), 32'd0);
    check({tag, ".early_err"}, 32'(frame_err), 32'd0);
    tick();
    check({tag, ".valid"}, 32'(frame_valid), 32'(exp_v));
    check({tag, ".err"}, 32'(frame_err), 32'(exp_e));
    check_outputs(tag);
    tick();
    check({tag, ".late_valid"}, 32'(frame_valid), 32'd0);
    check({tag, ".late_err"}, 32'(frame_err), 32'd0);
    stcp = 1'b0;
    shcp = 1'b0;
    tick(); tick();
    $display("latch %s: cnt=%0d simul=%0d valid=%0d err=%0d storage=%h", tag, cnt_m, simul, exp_v, exp_e, storage_m);
  endtask

  task automatic do_reset(input string tag, input int cycles);
    rst = 1'b1;
    for (int i = 0; i < cycles; i++) tick();
    rst = 1'b0;
    hist.delete();
    nbits     = 0;
    storage_m = '0;
    oe_m      = oe;
    check({tag, ".valid"}, 32'(frame_valid), 32'd0);
    check({tag, ".err"}, 32'(frame_err), 32'd0);
    check_outputs(tag);
    $display("reset %s: %0d cycles", tag, cycles);
  endtask

  task automatic set_oe(input string tag, input bit v);
    oe = v;
    tick();
    check_outputs({tag, ".before"});
    oe_m = v;
    tick();
    check_outputs({tag, ".after"});
    $display("oe %s: oe=%0d sel=%h seg=%h", tag, v, sel, seg);
  endtask

  initial begin
    nbits     = 0;
    storage_m = '0;
    oe_m      = 1'b0;
    tick();
    do_reset("por", 4);

    latch("empty", 1'b0, 1'b0);

    shift_word(W, 32'h303E);
    latch("f303e", 1'b0, 1'b0);

    shift_word(13, 32'($urandom));
    latch("short13", 1'b0, 1'b0);

    shift_word(20, 32'($urandom));
    latch("long20", 1'b0, 1'b0);

    shift_word(W, 32'($urandom));
    latch("simul", 1'b1, 1'($urandom));
    shift_word(13, 32'($urandom));
    latch("after_simul", 1'b0, 1'b0);

    shift_word(W, 32'h303E);
    latch("f303e_again", 1'b0, 1'b0);
    set_oe("blank", 1'b1);
    set_oe("unblank", 1'b0);

    shift_word(7, 32'h7F);
    do_reset("midframe", 1);
    shift_word(W, 32'h1555);
    latch("f1555", 1'b0, 1'b0);
    check("f1555.sel_const", 32'(sel), 32'h15);
    check("f1555.seg_const", 32'(seg), 32'h55);

    for (int r = 0; r < 12; r++) begin
      int len = $urandom_range(0, 18);
      if ($urandom_range(0, 2) == 0) len = W;
      shift_word(len, 32'($urandom));
      latch($sformatf("rand%0d", r), 1'($urandom_range(0, 3) == 0), 1'($urandom));
      if ($urandom_range(0, 3) == 0) begin
        set_oe($sformatf("rand%0d_oe1", r), 1'b1);
        set_oe($sformatf("rand%0d_oe0", r), 1'b0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
